// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one full-adder cell walks WIDTH-bit operands LSB first.
// Optional subtract support is enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             op_sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             busy_o
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
   logic [CntW-1:0]  cnt_q;
   logic             carry_q, cout_q, ovf_q, out_valid_q, in_ready_q, busy_q;

   logic [WIDTH-1:0] b_load;
   logic             carry_load;
   logic             fa_s, fa_co;

`ifdef SERIAL_ADD_SUB_EN
   // Subtraction as a + ~b + 1; cin is ignored for subtracts.
   always_comb begin
      b_load     = op_sub_i ? ~b_i : b_i;
      carry_load = op_sub_i ? 1'b1 : cin_i;
   end
`else
   logic unused_op_sub;
   assign unused_op_sub = op_sub_i;

   always_comb begin
      b_load     = b_i;
      carry_load = cin_i;
   end
`endif

   always_comb begin
      fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      fa_co = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  a_sh_q     <= a_i;
                  b_sh_q     <= b_load;
                  carry_q    <= carry_load;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StRun;
               end
            end
            StRun: begin
               sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
               a_sh_q  <= a_sh_q >> 1;
               b_sh_q  <= b_sh_q >> 1;
               carry_q <= fa_co;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LastCnt) begin
                  // carry_q here is the carry into the MSB.
                  ovf_q       <= carry_q ^ fa_co;
                  cout_q      <= fa_co;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign sum_o       = sum_q;
   assign cout_o      = cout_q;
   assign ovf_o       = ovf_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random operations
// checked against an arithmetic reference model.
module tb_serial_adder_ctrl;

   localparam int unsigned W = 8;
`ifdef SERIAL_ADD_SUB_EN
   localparam bit SubEn = 1'b1;
`else
   localparam bit SubEn = 1'b0;
`endif

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         in_valid_i = 1'b0;
   logic         in_ready_o;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         cin_i = 1'b0;
   logic         op_sub_i = 1'b0;
   logic         out_valid_o;
   logic         out_ready_i = 1'b0;
   logic [W-1:0] sum_o;
   logic         cout_o;
   logic         ovf_o;
   logic         busy_o;

   int n_checks = 0;
   int n_errors = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_i         (a_i),
      .b_i         (b_i),
      .cin_i       (cin_i),
      .op_sub_i    (op_sub_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .sum_o       (sum_o),
      .cout_o      (cout_o),
      .ovf_o       (ovf_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Returns {ovf, cout, sum} from plain integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
      logic [W:0]   full;
      logic [W-1:0] be;
      logic         ce;
      logic         ovf;
      be = b;
      ce = cin;
      if (sub && SubEn) begin
         be = ~b;
         ce = 1'b1;
      end
      full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
      ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
      return {ovf, full[W], full[W-1:0]};
   endfunction

   task automatic wait_accept(output bit acc);
      logic rdy;
      int   tries;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
         rdy = in_ready_o;
         @(posedge clk_i);
         #1;
         if (rdy) acc = 1'b1;
         tries++;
      end
      check("accept", 32'(acc), 32'd1);
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      while (!out_valid_o && edges < 3 * W) begin
         @(posedge clk_i);
         #1;
         edges++;
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int hold);
      logic [W+1:0] e;
      bit           acc;
      int           edges;
      e          = model(a, b, cin, sub);
      a_i        = a;
      b_i        = b;
      cin_i      = cin;
      op_sub_i   = sub;
      in_valid_i = 1'b1;
      wait_accept(acc);
      in_valid_i = 1'b0;
      a_i        = W'($urandom);
      b_i        = W'($urandom);
      cin_i      = 1'($urandom);
      op_sub_i   = 1'($urandom);
      check("busy_run", 32'(busy_o), 32'd1);
      check("rdy_run", 32'(in_ready_o), 32'd0);
      wait_valid(edges);
      check("latency", 32'(edges), 32'(W));
      check("sum", 32'(sum_o), 32'(e[W-1:0]));
      check("cout", 32'(cout_o), 32'(e[W]));
      check("ovf", 32'(ovf_o), 32'(e[W+1]));
      in_valid_i = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk_i);
         #1;
         check("hold_valid", 32'(out_valid_o), 32'd1);
         check("hold_rdy", 32'(in_ready_o), 32'd0);
         check("hold_sum", 32'(sum_o), 32'(e[W-1:0]));
         check("hold_cout", 32'(cout_o), 32'(e[W]));
         check("hold_ovf", 32'(ovf_o), 32'(e[W+1]));
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b0;
      check("hs_valid", 32'(out_valid_o), 32'd0);
      check("hs_rdy", 32'(in_ready_o), 32'd1);
      check("hs_busy", 32'(busy_o), 32'd0);
      check("idle_sum", 32'(sum_o), 32'(e[W-1:0]));
   endtask

   initial begin
      bit acc;
      int edges;
      #12;
      check("rst_rdy", 32'(in_ready_o), 32'd1);
      check("rst_valid", 32'(out_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_sum", 32'(sum_o), 32'd0);
      check("rst_cout", 32'(cout_o), 32'd0);
      check("rst_ovf", 32'(ovf_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      do_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
      do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1);
      do_op(8'h00, 8'h00, 1'b1, 1'b0, 0);
      do_op(8'h80, 8'h80, 1'b0, 1'b0, 5);

      // Reset in the middle of a run discards the operation.
      a_i        = 8'hFF;
      b_i        = 8'hFF;
      cin_i      = 1'b1;
      op_sub_i   = 1'b0;
      in_valid_i = 1'b1;
      wait_accept(acc);
      in_valid_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_valid", 32'(out_valid_o), 32'd0);
      check("mid_rst_sum", 32'(sum_o), 32'd0);
      check("mid_rst_rdy", 32'(in_ready_o), 32'd1);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      do_op(8'h12, 8'h34, 1'b0, 1'b0, 0);

      // Back-to-back with in_valid and out_ready held high.
      a_i         = 8'h01;
      b_i         = 8'h01;
      cin_i       = 1'b0;
      op_sub_i    = 1'b0;
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      wait_accept(acc);
      a_i = 8'hAA;
      b_i = 8'h55;
      wait_valid(edges);
      check("b2b_lat1", 32'(edges), 32'(W));
      check("b2b_sum1", 32'(sum_o), 32'h02);
      @(posedge clk_i);
      #1;
      check("b2b_hs_rdy", 32'(in_ready_o), 32'd1);
      check("b2b_hs_valid", 32'(out_valid_o), 32'd0);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      check("b2b_acc2", 32'(busy_o), 32'd1);
      wait_valid(edges);
      check("b2b_lat2", 32'(edges), 32'(W));
      check("b2b_sum2", 32'(sum_o), 32'hFF);
      check("b2b_cout2", 32'(cout_o), 32'd0);
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b0;
      check("b2b_end_rdy", 32'(in_ready_o), 32'd1);

      // op_sub: subtract when enabled, ignored otherwise.
      do_op(8'h05, 8'h07, 1'b0, 1'b1, 0);

      for (int i = 0; i < 40; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
